// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, mtime type, decode and byte-merge helpers.
package clint_pkg;

  typedef logic [63:0] mtime_t;

  localparam logic [15:0] OFF_MSIP        = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

  typedef enum logic [2:0] {
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI,
    SEL_NONE
  } reg_sel_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } apb_state_e;

  // Misaligned offsets never match an entry, so they fall into SEL_NONE.
  function automatic reg_sel_e decode_offset(logic [15:0] off);
    case (off)
      OFF_MSIP:        return SEL_MSIP;
      OFF_MTIMECMP_LO: return SEL_CMP_LO;
      OFF_MTIMECMP_HI: return SEL_CMP_HI;
      OFF_MTIME_LO:    return SEL_TIME_LO;
      OFF_MTIME_HI:    return SEL_TIME_HI;
      default:         return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] strb_merge(logic [31:0] old_val,
                                             logic [31:0] new_val,
                                             logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_clint_if.sv
// APB3/4 slave bus bundle for the CLINT register block.
interface apb_clint_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pwstrb,
    output pready, prdata, pslverr
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pwstrb,
    input  pready, prdata, pslverr
  );
endinterface

// File: rtl/clint_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, first tick TICK_DIV cycles after reset.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(TICK_DIV - 1));
  assign tick = wrap;

  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (wrap) cnt_q <= '0;
    else           cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/apb_clint.sv
// Core-local interruptor: msip, 64-bit mtime/mtimecmp on APB with one wait state per transfer.
module apb_clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  apb_clint_if.slave  apb,
  output logic        mtip,
  output logic        msip
);

  apb_state_e  state_q, state_d;
  reg_sel_e    sel;
  mtime_t      mtime_q, mtimecmp_q;
  logic        msip_q, mtip_q;
  logic        tick, access, complete, wr_en;
  logic [31:0] rd_val;
  logic        unused_paddr_hi;

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign unused_paddr_hi = ^apb.paddr[31:16];
  assign sel      = decode_offset(apb.paddr[15:0]);
  assign access   = apb.psel & apb.penable;
  // Gating with rst keeps a transfer caught by reset from completing or writing.
  assign complete = access & (state_q == ST_WAIT) & ~rst;
  assign wr_en    = complete & apb.pwrite & (sel != SEL_NONE) & (|apb.pwstrb);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_MSIP:    rd_val = {31'b0, msip_q};
      SEL_CMP_LO:  rd_val = mtimecmp_q[31:0];
      SEL_CMP_HI:  rd_val = mtimecmp_q[63:32];
      SEL_TIME_LO: rd_val = mtime_q[31:0];
      SEL_TIME_HI: rd_val = mtime_q[63:32];
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    apb.pready  = complete;
    apb.pslverr = complete & (sel == SEL_NONE);
    apb.prdata  = (complete & ~apb.pwrite) ? rd_val : '0;
  end

  // A write to either half wins over a same-cycle tick; the other half keeps its old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
    end else if (wr_en && sel == SEL_TIME_LO) begin
      mtime_q[31:0] <= strb_merge(mtime_q[31:0], apb.pwdata, apb.pwstrb);
    end else if (wr_en && sel == SEL_TIME_HI) begin
      mtime_q[63:32] <= strb_merge(mtime_q[63:32], apb.pwdata, apb.pwstrb);
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp_q <= '1;
    end else if (wr_en && sel == SEL_CMP_LO) begin
      mtimecmp_q[31:0] <= strb_merge(mtimecmp_q[31:0], apb.pwdata, apb.pwstrb);
    end else if (wr_en && sel == SEL_CMP_HI) begin
      mtimecmp_q[63:32] <= strb_merge(mtimecmp_q[63:32], apb.pwdata, apb.pwstrb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q <= 1'b0;
    end else if (wr_en && sel == SEL_MSIP && apb.pwstrb[0]) begin
      msip_q <= apb.pwdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mtip_q <= 1'b0;
    else     mtip_q <= (mtime_q >= mtimecmp_q);
  end

  assign mtip = mtip_q;
  assign msip = msip_q;

endmodule

// File: tb/tb_apb_clint.sv
// Directed bench for apb_clint (TICK_DIV=1 and 4) with a cycle-level reference model.
module tb_apb_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pwstrb;
  int unsigned tgt;
  logic        mtip0, msip0, mtip1, msip1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  apb_clint_if bus0 ();
  apb_clint_if bus1 ();

  assign bus0.psel    = psel && (tgt == 0);
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pwstrb  = pwstrb;
  assign bus1.psel    = psel && (tgt == 1);
  assign bus1.penable = penable;
  assign bus1.pwrite  = pwrite;
  assign bus1.paddr   = paddr;
  assign bus1.pwdata  = pwdata;
  assign bus1.pwstrb  = pwstrb;

  apb_clint #(.TICK_DIV(1)) dut0 (.clk(clk), .rst(rst), .apb(bus0), .mtip(mtip0), .msip(msip0));
  apb_clint #(.TICK_DIV(4)) dut1 (.clk(clk), .rst(rst), .apb(bus1), .mtip(mtip1), .msip(msip1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: one entry per instance, index 0 -> TICK_DIV=1, index 1 -> TICK_DIV=4.
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_msip [2];
  logic        m_mtip [2];
  int unsigned m_n    [2];
  int unsigned m_acc  [2];

  function automatic int unsigned div_of(int unsigned i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] bmask(logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] merged(logic [31:0] old_val);
    return (old_val & ~bmask(pwstrb)) | (pwdata & bmask(pwstrb));
  endfunction

  function automatic bit m_mapped(logic [31:0] a);
    case (a[15:0])
      16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(int unsigned i, logic [31:0] a);
    case (a[15:0])
      16'h0000: return {31'b0, m_msip[i]};
      16'h4000: return m_cmp[i][31:0];
      16'h4004: return m_cmp[i][63:32];
      16'hBFF8: return m_time[i][31:0];
      16'hBFFC: return m_time[i][63:32];
      default:  return 32'h0;
    endcase
  endfunction

  function automatic bit m_access(int unsigned i);
    return psel && (tgt == i) && penable;
  endfunction

  function automatic bit m_complete(int unsigned i);
    return m_access(i) && (m_acc[i] == 1) && !rst;
  endfunction

  function automatic bit m_wr(int unsigned i, logic [15:0] off);
    return m_complete(i) && pwrite && (pwstrb != 4'h0) && (paddr[15:0] == off);
  endfunction

  function automatic logic [63:0] m_next_time(int unsigned i);
    logic [63:0] t;
    t = m_time[i];
    if ((m_n[i] + 1) % div_of(i) == 0) t = m_time[i] + 64'd1;
    if (m_wr(i, 16'hBFF8)) t = {m_time[i][63:32], merged(m_time[i][31:0])};
    if (m_wr(i, 16'hBFFC)) t = {merged(m_time[i][63:32]), m_time[i][31:0]};
    return t;
  endfunction

  function automatic logic [63:0] m_next_cmp(int unsigned i);
    logic [63:0] c;
    c = m_cmp[i];
    if (m_wr(i, 16'h4000)) c = {m_cmp[i][63:32], merged(m_cmp[i][31:0])};
    if (m_wr(i, 16'h4004)) c = {merged(m_cmp[i][63:32]), m_cmp[i][31:0]};
    return c;
  endfunction

  always @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (rst) begin
        m_time[i] <= 64'h0;
        m_cmp[i]  <= 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip[i] <= 1'b0;
        m_mtip[i] <= 1'b0;
        m_n[i]    <= 0;
        m_acc[i]  <= 0;
      end else begin
        m_mtip[i] <= (m_time[i] >= m_cmp[i]);
        m_time[i] <= m_next_time(i);
        m_cmp[i]  <= m_next_cmp(i);
        m_msip[i] <= (m_wr(i, 16'h0000) && pwstrb[0]) ? pwdata[0] : m_msip[i];
        m_n[i]    <= m_n[i] + 1;
        m_acc[i]  <= m_complete(i) ? 0 : (m_access(i) ? m_acc[i] + 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        logic        c;
        logic [31:0] exp_rd;
        c      = m_complete(i);
        exp_rd = (c && !pwrite && m_mapped(paddr)) ? m_read(i, paddr) : 32'h0;
        chk($sformatf("pready%0d", i), (i == 0) ? bus0.pready : bus1.pready, c);
        chk($sformatf("pslverr%0d", i), (i == 0) ? bus0.pslverr : bus1.pslverr, c && !m_mapped(paddr));
        chk($sformatf("prdata%0d", i), (i == 0) ? bus0.prdata : bus1.prdata, exp_rd);
        chk($sformatf("mtip%0d", i), (i == 0) ? mtip0 : mtip1, m_mtip[i]);
        chk($sformatf("msip%0d", i), (i == 0) ? msip0 : msip1, m_msip[i]);
      end
    end
  end

  task automatic apb(input int unsigned t, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic err);
    int unsigned waits;
    bit          done;
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pwstrb = s;
    rd = 32'h0; err = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    waits = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if ((t == 0) ? bus0.pready : bus1.pready) begin
        rd   = (t == 0) ? bus0.prdata : bus1.prdata;
        err  = (t == 0) ? bus0.pslverr : bus1.pslverr;
        done = 1'b1;
        chk("wait_states", 64'(waits), 64'd1);
      end else if (++waits > 8) begin
        chk("pready_timeout", 64'(waits), 64'd1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int unsigned k;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pwstrb = '0; tgt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_pready0", bus0.pready, 1'b0);
    chk("rst_mtip0", mtip0, 1'b0);
    chk("rst_msip1", msip1, 1'b0);

    // Immediate mtime read, TICK_DIV=1: two ticks elapse before the completing cycle.
    apb(0, 1'b0, 32'h0000_BFF8, 32'h0, 4'hF, rd, err);
    chk("first_read_val", rd, 32'h2);
    chk("first_read_err", err, 1'b0);

    apb(0, 1'b1, 32'h0000_4000, 32'h0000_0020, 4'hF, rd, err);
    apb(0, 1'b1, 32'h0000_4004, 32'h0000_0000, 4'hF, rd, err);
    k = 0;
    while (m_time[0] != 64'h20 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mtime_reached_20", m_time[0], 64'h20);
    chk("mtip_same_cycle", mtip0, 1'b0);
    @(negedge clk);
    chk("mtip_one_later", mtip0, 1'b1);
    repeat (4) @(negedge clk);
    chk("mtip_stays", mtip0, 1'b1);

    // Carry from low to high half.
    apb(0, 1'b1, 32'h0000_BFFC, 32'h0000_0000, 4'hF, rd, err);
    apb(0, 1'b1, 32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, rd, err);
    apb(0, 1'b0, 32'h0000_BFFC, 32'h0, 4'hF, rd, err);
    chk("carry_hi", rd, 32'h1);
    apb(0, 1'b0, 32'h0000_BFF8, 32'h0, 4'hF, rd, err);
    chk("carry_lo", rd, 32'h4);

    apb(0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, rd, err);
    chk("msip_set", msip0, 1'b1);
    apb(0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, rd, err);
    chk("msip_read", rd, 32'h1);
    apb(0, 1'b1, 32'h0000_0000, 32'h0, 4'hF, rd, err);
    chk("msip_clear", msip0, 1'b0);

    // penable without psel must do nothing.
    pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h1; pwstrb = 4'hF; penable = 1'b1;
    repeat (3) @(posedge clk);
    #1 penable = 1'b0;
    chk("stray_penable_msip", msip0, 1'b0);

    apb(0, 1'b0, 32'h0000_1234, 32'h0, 4'hF, rd, err);
    chk("unmapped_err", err, 1'b1);
    chk("unmapped_data", rd, 32'h0);
    apb(0, 1'b1, 32'h0000_4002, 32'hDEAD_BEEF, 4'hF, rd, err);
    chk("misaligned_err", err, 1'b1);
    apb(0, 1'b1, 32'h0000_4000, 32'h0000_AB00, 4'b0010, rd, err);
    chk("strb_write_err", err, 1'b0);
    apb(0, 1'b0, 32'h0000_4000, 32'h0, 4'hF, rd, err);
    chk("strb_byte1", rd, 32'h0000_AB20);
    apb(0, 1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'b0000, rd, err);
    chk("strb0_err", err, 1'b0);
    apb(0, 1'b0, 32'h0000_4000, 32'h0, 4'hF, rd, err);
    chk("strb0_nowrite", rd, 32'h0000_AB20);
    apb(0, 1'b0, 32'h0000_4004, 32'h0, 4'hF, rd, err);
    chk("cmp_hi_kept", rd, 32'h0);

    // TICK_DIV=4 instance: reset lands in the completing cycle of an mtime write.
    apb(1, 1'b1, 32'h0000_4004, 32'h0000_0000, 4'hF, rd, err);
    tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0000_BFF8; pwdata = 32'h1234_5678; pwstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_pready1", bus1.pready, 1'b0);
    chk("abort_mtip1", mtip1, 1'b0);
    apb(1, 1'b0, 32'h0000_BFF8, 32'h0, 4'hF, rd, err);
    chk("div4_read0", rd, 32'h0);
    apb(1, 1'b0, 32'h0000_BFF8, 32'h0, 4'hF, rd, err);
    chk("div4_read1", rd, 32'h1);
    apb(1, 1'b0, 32'h0000_BFF8, 32'h0, 4'hF, rd, err);
    chk("div4_read2", rd, 32'h2);
    apb(1, 1'b0, 32'h0000_4004, 32'h0, 4'hF, rd, err);
    chk("div4_cmp_reset", rd, 32'hFFFF_FFFF);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
